// File: rtl/tree_adder_pkg.sv
// ============================================================================
// tree_adder_pkg : shared constants and width helper for the tree_adder block
// Rev 1.0
// ============================================================================
`default_nettype none

package tree_adder_pkg;

  localparam int N_ROWS       = 16;
  localparam int N_COLS       = 16;
  localparam int N_ELEMS      = N_ROWS * N_COLS;
  localparam int LEVELS       = 8;
  localparam int BASE_LATENCY = LEVELS;

  // Output width of tree level k; level 0 is the raw input element.
  function automatic int level_width(input int width, input int k);
    return width + k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tree_adder_level.sv
// ============================================================================
// tree_adder_level : one registered level of sign-extended pairwise additions
// Rev 1.0
// ============================================================================
`default_nettype none

module tree_adder_level #(
  parameter int N_IN = 256,
  parameter int IN_W = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [N_IN-1:0][IN_W-1:0]   din,
  output logic [N_IN/2-1:0][IN_W:0]   dout
);

  logic [N_IN/2-1:0][IN_W:0] sum_next;

  // One extra bit per level keeps every pairwise sum exact.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      sum_next[i] = {din[2*i][IN_W-1], din[2*i]} + {din[2*i+1][IN_W-1], din[2*i+1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      dout <= '0;
    end else if (enable) begin
      dout <= sum_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tree_adder.sv
// ============================================================================
// tree_adder : 8-level pipelined signed reduction of a 16x16 sample array.
// Option TREE_ADDER_INPUT_REG_EN adds an input register (latency 9 vs 8).
// Rev 1.0
// ============================================================================
`default_nettype none

module tree_adder
  import tree_adder_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [WIDTH-1:0]  array [N_ROWS][N_COLS],
  output logic signed [WIDTH+7:0]  sum_result
);

  logic [N_ELEMS-1:0][WIDTH-1:0] flat;
  logic [N_ELEMS-1:0][WIDTH-1:0] lvl_in;

  always_comb begin
    flat = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        flat[r*N_COLS+c] = array[r][c];
      end
    end
  end

`ifdef TREE_ADDER_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lvl_in <= '0;
    end else if (enable) begin
      lvl_in <= flat;
    end
  end
`else
  assign lvl_in = flat;
`endif

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int N_IN = N_ELEMS >> (k - 1);
    localparam int IN_W = level_width(WIDTH, k - 1);

    logic [N_IN-1:0][IN_W-1:0]   din;
    logic [N_IN/2-1:0][IN_W:0]   dout;

    if (k == 1) begin : g_first
      assign din = lvl_in;
    end else begin : g_next
      assign din = g_level[k-1].dout;
    end

    tree_adder_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .din    (din),
      .dout   (dout)
    );
  end

  assign sum_result = g_level[LEVELS].dout[0];

endmodule

`default_nettype wire

// File: tb/tb_tree_adder.sv
// ============================================================================
// tb_tree_adder : directed scoreboard bench for tree_adder (WIDTH=9).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tree_adder;

  localparam int WIDTH = 9;
`ifdef TREE_ADDER_INPUT_REG_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic signed [WIDTH-1:0] arr [16][16];
  logic signed [WIDTH+7:0] sum_result;

  typedef struct {
    int exp;
    int due;
  } sb_t;

  sb_t q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  en_cnt   = 0;
  int  last_exp = 0;

  tree_adder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .array      (arr),
    .sum_result (sum_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        arr[r][c] = v[WIDTH-1:0];
  endtask

  // One clock; optionally records the result owed for the array now applied.
  task automatic tick(input bit push, input int exp);
    if (push && enable && !rst_n) q.push_back('{exp, en_cnt + LAT});
    @(posedge clk);
    if (rst_n) begin
      q.delete();
      last_exp = 0;
    end else if (enable) begin
      en_cnt++;
    end
    #1;
    if (q.size() > 0 && q[0].due == en_cnt) begin
      sb_t e = q.pop_front();
      check("result", int'(sum_result), e.exp);
      last_exp = e.exp;
    end
  endtask

  task automatic feed(input int v, input int exp);
    set_all(v);
    tick(1'b1, exp);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      tick(1'b0, 0);
      n++;
    end
    check("drain_pending", q.size(), 0);
  endtask

  initial begin
    // Reset with arbitrary data present
    rst_n  = 1'b1;
    enable = 1'b1;
    set_all(77);
    repeat (3) tick(1'b0, 0);
    check("reset_zero", int'(sum_result), 0);

    // Release: output stays 0 through pipeline fill
    rst_n = 1'b0;
    feed(-255, -65280);
    for (int i = 0; i < LAT - 2; i++) begin
      tick(1'b0, 0);
      check("fill_zero", int'(sum_result), 0);
    end
    drain();

    // Back-to-back streaming, including 9-bit wrap of the applied values
    feed(23, 5888);
    feed(68, 17408);
    feed(-412, 25600);
    feed(-689, -45312);
    feed(88, 22528);
    drain();

    // Extremes and positional weighting
    feed(-256, -65536);
    feed(255, 65280);
    set_all(0);
    arr[15][15] = 9'sd1;
    tick(1'b1, 1);
    set_all(0);
    arr[0][0] = -9'sd1;
    arr[7][8] = 9'sd2;
    tick(1'b1, 1);
    drain();

    // Enable stall mid-stream
    feed(10, 2560);
    feed(20, 5120);
    feed(30, 7680);
    feed(40, 10240);
    feed(50, 12800);
    set_all(0);
    repeat (LAT - 4) tick(1'b0, 0);
    check("pre_stall", last_exp, 5120);
    enable = 1'b0;
    set_all(99);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 0);
      check("stall_hold", int'(sum_result), 5120);
    end
    enable = 1'b1;
    drain();
    check("post_stall_last", last_exp, 12800);

    // Reset while four results are in flight
    feed(1, 256);
    feed(2, 512);
    feed(3, 768);
    feed(4, 1024);
    rst_n = 1'b1;
    tick(1'b0, 0);
    check("midrst_zero", int'(sum_result), 0);
    rst_n = 1'b0;
    feed(5, 1280);
    check("refill_zero", int'(sum_result), 0);
    for (int i = 0; i < LAT - 2; i++) begin
      tick(1'b0, 0);
      check("refill_zero", int'(sum_result), 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tree_adder.md
# tree_adder

Pipelined signed reduction adder that sums a 16×16 array of signed samples into one full-precision result. It sits in the image-processing pipeline after the per-pixel difference/product stage and feeds block-level accumulation/compare logic. The adder is a binary tree of eight pairwise-add levels, registered per level, with a global clock enable.

## Interface
- WIDTH, 9, bit width of each signed input element; the output is WIDTH+8 bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-high reset. Despite the name, 1 = reset asserted. It is sampled on the rising edge of clk.
- enable  input  1  pipeline clock enable; 1 = all stages advance this cycle.
- array  input  signed [WIDTH-1:0] [16][16]  operands; unpacked 16×16 array of two's-complement values.
- sum_result  output  signed [WIDTH+7:0]  registered sum of all 256 elements.

## Operation
- Level 1: the 256 elements, flattened row-major (index = row*16+col), form 128 pairs (2i, 2i+1). Each pair is summed at width WIDTH+1.
- Level k (k = 1..8): 256/2^k adders. Inputs are WIDTH+k-1 bits and are sign-extended. Outputs are WIDTH+k bits. Level 8 produces the single WIDTH+8-bit result.
- All arithmetic is signed two's complement and full precision. No saturation, rounding or truncation is permitted.
- Range: WIDTH+8 bits exactly covers 256 × [−2^(WIDTH−1), 2^(WIDTH−1)−1], so overflow is impossible. For WIDTH=9 the range is −65536..65280.
- Each level's outputs are registered. sum_result is the level-8 register.
- When enable=1, every stage register loads its new value on the rising edge.
- When enable=0, every stage register, including sum_result, holds its value. In-flight data is neither lost nor duplicated.
- Reset when rst_n=1 at a rising edge:
  - All stage registers and sum_result clear to 0.
  - Reset has priority over enable.
  - Reset mid-operation discards all in-flight partial sums.

## Timing
- Latency is 8 enabled cycles. Operands sampled at enabled edge n appear on sum_result after enabled edge n+7, i.e. they are visible between edges n+7 and n+8.
- Throughput is one new array per enabled cycle. The design is fully pipelined with no handshake and no stall output.
- Latency is counted in enabled edges only. Disabled cycles stretch the wall-clock delay but do not reorder results.
- After reset deasserts, sum_result stays 0 until the first valid result emerges 8 enabled edges later. Intermediate values during pipeline fill are sums of zeros and partial data, and consumers must ignore them.
- There is no combinational path from array to sum_result.

## Configuration
- TREE_ADDER_INPUT_REG_EN: when defined, an extra register stage captures array, gated by the same enable and reset, before level 1.
  - Latency becomes 9 enabled edges.
  - Eases timing when array comes from distant logic.
- When undefined, level 1 adds array directly and latency is 8.
- Arithmetic results are identical in both builds.

## Structure
- Package tree_adder_pkg holds:
  - N_ROWS=16, N_COLS=16, N_ELEMS=256, LEVELS=8.
  - A function giving the level-k width (WIDTH+k).
  - The base latency constant.
- Sub-module tree_adder_level:
  - Parameters N_IN and IN_W.
  - Performs N_IN/2 sign-extended pairwise additions into an enabled, synchronously reset register bank.
  - tree_adder instantiates it 8 times via generate.

## Test plan
Expected values are for WIDTH=9 with the default build; stimulus is held and enable=1 unless stated.
- Reset: hold rst_n=1 for 3 edges with arbitrary array → sum_result=0. Release; with all elements −255, after 8 enabled edges → −65280.
- Streaming: apply all 23, all 68, all 100, all −177, all 88 on consecutive enabled edges → results 5888, 17408, 25600, −45312, 22528 on consecutive cycles, starting 8 edges after the first. A 9-bit −412 wraps to 100 and −689 wraps to −177.
- Extremes: all −256 → −65536; all 255 → 65280. There must be no wrap.
- Positional weighting: single element array[15][15]=1, all others 0 → 1. Then array[0][0]=−1 with array[7][8]=2, all others 0 → 1.
- Enable stall: drop enable for 5 cycles mid-stream → sum_result frozen. After re-enable the remaining results appear in order with no loss.
- Reset mid-stream: assert rst_n for 1 edge while 4 results are in flight → output 0 and stays 0 until new data traverses 8 edges.
